rotate_addr_gen: RTL and testbench
==================================

# rotate_addr_gen

Parametrised tile-based address generator for the image rotation engine, successor to the fixed 8x8 RGB core sequencer. For every square tile of the image it issues TILE×TILE source read addresses, then TILE×TILE destination write addresses, transformed for 0/90/180/270 degrees in either direction. It sits between the register block (image geometry, bases, mode) and the DMA master, which accepts one beat per `I_DMA_READY`.

## Interface
Parameters:
- ADDR_W, 32, address width of O_ADDR and base inputs
- DIM_W, 16, width of height/width inputs
- TILE_LOG2, 3, log2 of tile edge T (T = 8 by default)
- BPP, 3, bytes per pixel (address step per pixel)
- HSIZE, 3'h2, constant value driven on O_SIZE

Ports:
- I_HCLK  in  1  clock, rising edge
- I_HRESET  in  1  reset, synchronous, active-high
- I_START  in  1  start request, honoured only in IDLE
- I_HEIGHT  in  DIM_W  source height in pixels
- I_WIDTH  in  DIM_W  source width in pixels
- I_SRC_BASE  in  ADDR_W  source buffer base byte address
- I_DST_BASE  in  ADDR_W  destination buffer base byte address
- I_DIRECTION  in  1  1 = clockwise, 0 = counter-clockwise
- I_DEGREES  in  3  0=0°, 1=90°, 2=180°, 3=270°; 4..7 invalid
- I_DMA_READY  in  1  DMA accepts current beat
- O_ADDR  out  ADDR_W  beat byte address
- O_SIZE  out  3  transfer size, constant HSIZE
- O_WRITE  out  1  1 = write beat, 0 = read beat
- O_VALID  out  1  O_ADDR/O_WRITE carry a beat
- O_BUSY  out  1  job in progress
- O_COUNT  out  2*TILE_LOG2  beat index within current tile phase
- O_DONE  out  1  one-cycle pulse, job complete
- O_ERR  out  1  one-cycle pulse, start rejected

## Operation
- Geometry latched on accepted start. PH = I_HEIGHT rounded up to multiple of T, PW likewise. Source buffer is padded: stride PW*BPP.
- Rejection (O_ERR, stay IDLE, no beats): height or width zero, I_HEIGHT or I_WIDTH > 2^DIM_W − T, I_DEGREES > 3.
- Effective clockwise angle: CW → I_DEGREES; CCW → (4 − I_DEGREES) mod 4.
- Destination dims: 0/180 → DH=PH, DW=PW; 90/270 → DH=PW, DW=PH.
- Tile order: tile column tx outer (0..PW/T−1), tile row ty inner (0..PH/T−1).
- Per tile: READ phase T*T beats, pixel (r,c) row-major, r,c in 0..T−1; then WRITE phase T*T beats in the same (r,c) order. Source pixel y = ty*T+r, x = tx*T+c.
- Read address: I_SRC_BASE + (y*PW + x)*BPP.
- Write mapping (y,x)→(y',x'): 0: (y,x); 90: (x, PH−1−y); 180: (PH−1−y, PW−1−x); 270: (PW−1−x, y). Write address: I_DST_BASE + (y'*DW + x')*BPP.
- All address arithmetic modulo 2^ADDR_W; intermediates at least 2*DIM_W+2 bits wide, no intermediate truncation.
- States: IDLE → READ on valid start; READ → WRITE after beat T*T−1 accepted; WRITE → READ after beat T*T−1 accepted if tiles remain, else → IDLE with O_DONE pulse.
- O_COUNT = r*T+c; resets to 0 at each phase change.
- I_START while busy ignored; geometry/mode input changes during a job ignored.

## Timing
- Reset: all outputs 0 except O_SIZE = HSIZE; state IDLE; counters 0. Reset mid-job aborts immediately, no O_DONE.
- Beat accepted when O_VALID && I_DMA_READY at rising edge; counters advance only on accept.
- O_ADDR, O_WRITE, O_COUNT stable while O_VALID && !I_DMA_READY.
- Start accepted at edge N → O_BUSY=1, O_VALID=1, first read address at cycle N+1. Rejected start → O_ERR=1 at cycle N+1 only.
- No bubbles: READ→WRITE and WRITE→READ switch in the cycle after the last accept; O_VALID stays high.
- Last write accepted at edge M → cycle M+1: IDLE, O_BUSY=0, O_VALID=0, O_DONE=1 for one cycle. Start accepted in that cycle is legal.
- O_VALID=1 exactly in READ/WRITE; O_BUSY = O_VALID.

## Test plan
- 8x8, CW 0°, src 0x0, dst 0x1000, ready always 1 → reads 0,3,…,21,24,…,189; writes 0x1000..0x10BD same pattern; O_DONE 128 cycles after start.
- 8x8, CW 90° → first write 0x1000+21 (0,7), second 0x1000+45 (1,7), 8th 0x1000+189; CCW 270° run gives identical address stream.
- H=10, W=12, 180° → PH=PW=16, 4 tiles, 512 beats; tile 2 (tx=0,ty=1) first read = 384; first write = dst+765.
- Backpressure: ready toggled pseudo-randomly → address stream identical to ready-high run, O_ADDR held during stalls.
- I_DEGREES=4, then H=0 → O_ERR one cycle each, O_VALID never high; I_START during job ignored.
- Reset asserted at beat 70 → next cycle O_VALID=O_BUSY=0, no O_DONE; fresh start reproduces first beat address.

Source files
------------

// File: rtl/rotate_addr_gen.sv
// Tile-based rotation address generator: per TxT tile, a row-major read burst then a rotated write burst.
// Latency: first beat the cycle after start; no bubbles between phases. Backpressure: holds the beat while I_DMA_READY is low.
module rotate_addr_gen #(
    parameter int         ADDR_W    = 32,
    parameter int         DIM_W     = 16,
    parameter int         TILE_LOG2 = 3,
    parameter int         BPP       = 3,
    parameter logic [2:0] HSIZE     = 3'h2
) (
    input  logic                   I_HCLK,
    input  logic                   I_HRESET,
    input  logic                   I_START,
    input  logic [DIM_W-1:0]       I_HEIGHT,
    input  logic [DIM_W-1:0]       I_WIDTH,
    input  logic [ADDR_W-1:0]      I_SRC_BASE,
    input  logic [ADDR_W-1:0]      I_DST_BASE,
    input  logic                   I_DIRECTION,
    input  logic [2:0]             I_DEGREES,
    input  logic                   I_DMA_READY,
    output logic [ADDR_W-1:0]      O_ADDR,
    output logic [2:0]             O_SIZE,
    output logic                   O_WRITE,
    output logic                   O_VALID,
    output logic                   O_BUSY,
    output logic [2*TILE_LOG2-1:0] O_COUNT,
    output logic                   O_DONE,
    output logic                   O_ERR
);
    localparam int T     = 1 << TILE_LOG2;
    localparam int CNT_W = 2 * TILE_LOG2;
    localparam int MW    = 2 * DIM_W + 8;
    localparam int EW    = (ADDR_W > MW) ? ADDR_W : MW;
    localparam logic [DIM_W:0]   DIM_LIM = (DIM_W+1)'(1) << DIM_W;
    localparam logic [DIM_W:0]   MAX_DIM = DIM_LIM - (DIM_W+1)'(T);
    localparam logic [DIM_W-1:0] T_M1    = DIM_W'(T - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIM_W-1:0]  tx_q, tx_d, ty_q, ty_d;
    logic [DIM_W-1:0]  ph_q, ph_d, pw_q, pw_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [1:0]        ang_q, ang_d;
    logic              done_q, done_d, err_q, err_d;

    logic              accept, last_beat, last_tile, start_bad;
    logic [DIM_W-1:0]  ph_rnd, pw_rnd, y, x, yy, xx, row_len;
    logic [1:0]        ang_in;
    logic [EW-1:0]     off;
    logic [ADDR_W-1:0] base;

    assign accept    = (state_q != ST_IDLE) && I_DMA_READY;
    assign last_beat = &cnt_q;
    assign last_tile = (tx_q == (pw_q >> TILE_LOG2) - DIM_W'(1))
                    && (ty_q == (ph_q >> TILE_LOG2) - DIM_W'(1));
    assign start_bad = (I_HEIGHT == '0) || (I_WIDTH == '0) || I_DEGREES[2]
                    || ({1'b0, I_HEIGHT} > MAX_DIM) || ({1'b0, I_WIDTH} > MAX_DIM);
    // Bounded dimensions guarantee the round-up cannot overflow DIM_W.
    assign ph_rnd    = (I_HEIGHT + T_M1) & ~T_M1;
    assign pw_rnd    = (I_WIDTH + T_M1) & ~T_M1;
    assign ang_in    = I_DIRECTION ? I_DEGREES[1:0] : 2'd0 - I_DEGREES[1:0];
    assign y         = (ty_q << TILE_LOG2) | DIM_W'(cnt_q[CNT_W-1:TILE_LOG2]);
    assign x         = (tx_q << TILE_LOG2) | DIM_W'(cnt_q[TILE_LOG2-1:0]);

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            ty_q    <= '0;
            ph_q    <= '0;
            pw_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            ang_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            ph_q    <= ph_d;
            pw_q    <= pw_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            ang_q   <= ang_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        ph_d    = ph_q;
        pw_d    = pw_q;
        src_d   = src_q;
        dst_d   = dst_q;
        ang_d   = ang_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_START) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        cnt_d   = '0;
                        tx_d    = '0;
                        ty_d    = '0;
                        ph_d    = ph_rnd;
                        pw_d    = pw_rnd;
                        src_d   = I_SRC_BASE;
                        dst_d   = I_DST_BASE;
                        ang_d   = ang_in;
                    end
                end
            end
            ST_READ: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        if (last_tile) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_READ;
                            // Tile rows run inner, tile columns outer.
                            if (ty_q == (ph_q >> TILE_LOG2) - DIM_W'(1)) begin
                                ty_d = '0;
                                tx_d = tx_q + DIM_W'(1);
                            end else begin
                                ty_d = ty_q + DIM_W'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        yy      = y;
        xx      = x;
        row_len = pw_q;
        if (state_q == ST_WRITE) begin
            case (ang_q)
                2'd1: begin yy = x; xx = ph_q - DIM_W'(1) - y; row_len = ph_q; end
                2'd2: begin yy = ph_q - DIM_W'(1) - y; xx = pw_q - DIM_W'(1) - x; end
                2'd3: begin yy = pw_q - DIM_W'(1) - x; xx = y; row_len = ph_q; end
                default: ;
            endcase
        end
        off     = (EW'(yy) * EW'(row_len) + EW'(xx)) * EW'(BPP);
        base    = (state_q == ST_WRITE) ? dst_q : src_q;
        O_VALID = (state_q != ST_IDLE);
        O_BUSY  = (state_q != ST_IDLE);
        O_WRITE = (state_q == ST_WRITE);
        O_ADDR  = O_VALID ? base + ADDR_W'(off) : '0;
        O_SIZE  = HSIZE;
        O_COUNT = cnt_q;
        O_DONE  = done_q;
        O_ERR   = err_q;
    end
endmodule

// File: tb/tb_rotate_addr_gen.sv
// Bench for rotate_addr_gen: randomized jobs and backpressure checked against a pixel-level model.
module tb_rotate_addr_gen;
    logic        I_HCLK = 1'b0;
    logic        I_HRESET, I_START, I_DIRECTION, I_DMA_READY;
    logic [15:0] I_HEIGHT, I_WIDTH;
    logic [31:0] I_SRC_BASE, I_DST_BASE, O_ADDR;
    logic [2:0]  I_DEGREES, O_SIZE;
    logic        O_WRITE, O_VALID, O_BUSY, O_DONE, O_ERR;
    logic [5:0]  O_COUNT;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [5:0]  cnt;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] cap_q[$];
    int          checks = 0;
    int          errors = 0;

    rotate_addr_gen dut (
        .I_HCLK(I_HCLK), .I_HRESET(I_HRESET), .I_START(I_START),
        .I_HEIGHT(I_HEIGHT), .I_WIDTH(I_WIDTH),
        .I_SRC_BASE(I_SRC_BASE), .I_DST_BASE(I_DST_BASE),
        .I_DIRECTION(I_DIRECTION), .I_DEGREES(I_DEGREES), .I_DMA_READY(I_DMA_READY),
        .O_ADDR(O_ADDR), .O_SIZE(O_SIZE), .O_WRITE(O_WRITE), .O_VALID(O_VALID),
        .O_BUSY(O_BUSY), .O_COUNT(O_COUNT), .O_DONE(O_DONE), .O_ERR(O_ERR)
    );

    always #5 I_HCLK = ~I_HCLK;

    // Expected beat stream straight from the pixel mapping rules.
    function automatic void build_model(input int h, input int w, input bit dir, input int deg,
                                        input logic [31:0] src, input logic [31:0] dst);
        longint ph, pw, ang, dw, y, x, yy, xx;
        beat_t  b;
        exp_q.delete();
        ph  = ((h + 7) / 8) * 8;
        pw  = ((w + 7) / 8) * 8;
        ang = dir ? deg : (4 - deg) % 4;
        dw  = (ang % 2 == 1) ? ph : pw;
        for (longint tx = 0; tx < pw / 8; tx++)
            for (longint ty = 0; ty < ph / 8; ty++)
                for (int wr = 0; wr < 2; wr++)
                    for (int p = 0; p < 64; p++) begin
                        y = ty * 8 + p / 8;
                        x = tx * 8 + p % 8;
                        b.wr  = wr[0];
                        b.cnt = 6'(p);
                        if (wr == 0) begin
                            b.addr = 32'(longint'(src) + (y * pw + x) * 3);
                        end else begin
                            case (ang)
                                1:       begin yy = x;          xx = ph - 1 - y; end
                                2:       begin yy = ph - 1 - y; xx = pw - 1 - x; end
                                3:       begin yy = pw - 1 - x; xx = y;          end
                                default: begin yy = y;          xx = x;          end
                            endcase
                            b.addr = 32'(longint'(dst) + (yy * dw + xx) * 3);
                        end
                        exp_q.push_back(b);
                    end
    endfunction

    task automatic run_job(input int h, input int w, input bit dir, input int deg,
                           input logic [31:0] src, input logic [31:0] dst,
                           input bit rnd_ready, input int abort_at, input bit poke,
                           output int ncyc);
        int idx = 0;
        int n;
        build_model(h, w, dir, deg, src, dst);
        n = exp_q.size();
        cap_q.delete();
        ncyc = 0;
        @(negedge I_HCLK);
        I_HEIGHT = 16'(h); I_WIDTH = 16'(w); I_DIRECTION = dir; I_DEGREES = 3'(deg);
        I_SRC_BASE = src; I_DST_BASE = dst; I_START = 1'b1; I_DMA_READY = 1'b0;
        @(negedge I_HCLK);
        I_START = 1'b0;
        checks++;
        if (O_BUSY !== 1'b1 || O_VALID !== 1'b1) begin
            errors++;
            $display("FAIL start_latency busy=%b valid=%b expected 1 1", O_BUSY, O_VALID);
        end
        while (idx < n && ncyc < 20000) begin
            checks++;
            if (O_VALID !== 1'b1 || O_WRITE !== exp_q[idx].wr || O_ADDR !== exp_q[idx].addr
                || O_COUNT !== exp_q[idx].cnt) begin
                errors++;
                $display("FAIL beat%0d got v=%b wr=%b addr=%h cnt=%0d expected v=1 wr=%b addr=%h cnt=%0d",
                         idx, O_VALID, O_WRITE, O_ADDR, O_COUNT,
                         exp_q[idx].wr, exp_q[idx].addr, exp_q[idx].cnt);
            end
            if (idx == abort_at) begin
                I_HRESET = 1'b1;
                @(negedge I_HCLK);
                I_HRESET = 1'b0;
                checks++;
                if (O_VALID !== 1'b0 || O_BUSY !== 1'b0 || O_DONE !== 1'b0) begin
                    errors++;
                    $display("FAIL abort got v=%b busy=%b done=%b expected 0 0 0", O_VALID, O_BUSY, O_DONE);
                end
                return;
            end
            // Start pulses and geometry changes mid-job must be ignored.
            if (poke && idx >= 5 && idx < 9) begin
                I_START = 1'b1; I_HEIGHT = 16'($urandom); I_WIDTH = 16'($urandom);
                I_DEGREES = 3'($urandom); I_DIRECTION = ~dir; I_SRC_BASE = $urandom;
            end else begin
                I_START = 1'b0;
            end
            I_DMA_READY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (I_DMA_READY) begin
                cap_q.push_back(O_ADDR);
                idx++;
            end
            @(negedge I_HCLK);
            ncyc++;
        end
        I_DMA_READY = 1'b0;
        I_START = 1'b0;
        checks++;
        if (idx < n) begin
            errors++;
            $display("FAIL job_timeout beats=%0d expected %0d", idx, n);
        end
        checks++;
        if (O_DONE !== 1'b1 || O_VALID !== 1'b0 || O_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle got done=%b v=%b busy=%b expected 1 0 0", O_DONE, O_VALID, O_BUSY);
        end
        @(negedge I_HCLK);
        checks++;
        if (O_DONE !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got done=%b expected 0", O_DONE);
        end
    endtask

    task automatic test_reset;
        I_HRESET = 1'b1; I_START = 1'b0; I_HEIGHT = '0; I_WIDTH = '0; I_DIRECTION = 1'b0;
        I_DEGREES = '0; I_SRC_BASE = '0; I_DST_BASE = '0; I_DMA_READY = 1'b0;
        repeat (3) @(negedge I_HCLK);
        checks++;
        if (O_ADDR !== 32'h0 || O_SIZE !== 3'h2 || O_WRITE !== 1'b0 || O_VALID !== 1'b0
            || O_BUSY !== 1'b0 || O_COUNT !== 6'd0 || O_DONE !== 1'b0 || O_ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got addr=%h size=%h wr=%b v=%b busy=%b cnt=%0d done=%b err=%b expected size=2 others 0",
                     O_ADDR, O_SIZE, O_WRITE, O_VALID, O_BUSY, O_COUNT, O_DONE, O_ERR);
        end
        I_HRESET = 1'b0;
    endtask

    task automatic test_rot0;
        int ncyc;
        run_job(8, 8, 1'b1, 0, 32'h0, 32'h1000, 1'b0, -1, 1'b0, ncyc);
        checks++;
        if (cap_q.size() != 128 || cap_q[7] !== 32'd21 || cap_q[8] !== 32'd24 || cap_q[63] !== 32'd189
            || cap_q[64] !== 32'h1000 || cap_q[127] !== 32'h10BD) begin
            errors++;
            $display("FAIL rot0_points got n=%0d a7=%h a8=%h a63=%h a64=%h a127=%h expected 128 15 18 bd 1000 10bd",
                     cap_q.size(), cap_q[7], cap_q[8], cap_q[63], cap_q[64], cap_q[127]);
        end
        checks++;
        if (ncyc != 128) begin
            errors++;
            $display("FAIL rot0_cycles got %0d expected 128", ncyc);
        end
    endtask

    task automatic test_rot90;
        int ncyc;
        int diffs = 0;
        logic [31:0] cw_q[$];
        run_job(8, 8, 1'b1, 1, 32'h0, 32'h1000, 1'b0, -1, 1'b0, ncyc);
        checks++;
        if (cap_q[64] !== 32'h1015 || cap_q[65] !== 32'h102D || cap_q[71] !== 32'h10BD) begin
            errors++;
            $display("FAIL rot90_points got %h %h %h expected 1015 102d 10bd", cap_q[64], cap_q[65], cap_q[71]);
        end
        cw_q = cap_q;
        run_job(8, 8, 1'b0, 3, 32'h0, 32'h1000, 1'b0, -1, 1'b0, ncyc);
        foreach (cw_q[i]) if (i >= cap_q.size() || cap_q[i] !== cw_q[i]) diffs++;
        checks++;
        if (diffs != 0 || cap_q.size() != cw_q.size()) begin
            errors++;
            $display("FAIL ccw270_vs_cw90 got %0d differing beats expected 0", diffs);
        end
    endtask

    task automatic test_rot180_pad;
        int ncyc;
        run_job(10, 12, 1'b1, 2, 32'h0, 32'h4000, 1'b0, -1, 1'b0, ncyc);
        checks++;
        if (cap_q.size() != 512 || cap_q[128] !== 32'd384 || cap_q[64] !== 32'h4000 + 32'd765) begin
            errors++;
            $display("FAIL rot180_points got n=%0d tile2_rd=%h first_wr=%h expected 512 180 42fd",
                     cap_q.size(), cap_q[128], cap_q[64]);
        end
    endtask

    task automatic test_backpressure;
        int ncyc;
        for (int j = 0; j < 4; j++)
            run_job(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), 1'($urandom),
                    int'($urandom_range(0, 3)), $urandom, $urandom, 1'b1, -1, j[0], ncyc);
    endtask

    task automatic test_reject;
        int hs[4] = '{8, 0, 8, 65529};
        int ws[4] = '{8, 8, 0, 8};
        int ds[4] = '{4, 1, 2, 0};
        for (int i = 0; i < 4; i++) begin
            @(negedge I_HCLK);
            I_HEIGHT = 16'(hs[i]); I_WIDTH = 16'(ws[i]); I_DEGREES = 3'(ds[i]);
            I_DIRECTION = 1'b1; I_START = 1'b1;
            @(negedge I_HCLK);
            I_START = 1'b0;
            checks++;
            if (O_ERR !== 1'b1 || O_VALID !== 1'b0) begin
                errors++;
                $display("FAIL reject%0d got err=%b v=%b expected 1 0", i, O_ERR, O_VALID);
            end
            @(negedge I_HCLK);
            checks++;
            if (O_ERR !== 1'b0 || O_VALID !== 1'b0 || O_BUSY !== 1'b0) begin
                errors++;
                $display("FAIL reject%0d_after got err=%b v=%b busy=%b expected 0 0 0", i, O_ERR, O_VALID, O_BUSY);
            end
        end
        // Largest legal geometry: accepted, wide row stride.
        @(negedge I_HCLK);
        I_HEIGHT = 16'd65528; I_WIDTH = 16'd65528; I_DEGREES = 3'd0; I_SRC_BASE = 32'h100;
        I_START = 1'b1; I_DMA_READY = 1'b1;
        @(negedge I_HCLK);
        I_START = 1'b0;
        checks++;
        if (O_ERR !== 1'b0 || O_VALID !== 1'b1 || O_ADDR !== 32'h100) begin
            errors++;
            $display("FAIL max_geom_start got err=%b v=%b addr=%h expected 0 1 100", O_ERR, O_VALID, O_ADDR);
        end
        repeat (8) @(negedge I_HCLK);
        checks++;
        if (O_ADDR !== 32'h300E8 || O_COUNT !== 6'd8) begin
            errors++;
            $display("FAIL max_geom_row1 got addr=%h cnt=%0d expected 300e8 8", O_ADDR, O_COUNT);
        end
        I_DMA_READY = 1'b0; I_HRESET = 1'b1;
        @(negedge I_HCLK);
        I_HRESET = 1'b0;
    endtask

    task automatic test_reset_mid;
        int ncyc;
        run_job(16, 16, 1'b1, 1, 32'h2000, 32'h8000, 1'b0, 70, 1'b0, ncyc);
        run_job(16, 16, 1'b1, 1, 32'h2000, 32'h8000, 1'b0, -1, 1'b0, ncyc);
        checks++;
        if (cap_q[0] !== 32'h2000) begin
            errors++;
            $display("FAIL restart_first got %h expected 2000", cap_q[0]);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rot0();
        test_rot90();
        test_rot180_pad();
        test_backpressure();
        test_reject();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
